// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter sequencer:
//   - PCSrc encodings (PC_SEQ .. PC_RET); codes 6 and 7 behave as PC_SEQ
//   - sequencer state enum (ST_RUN, ST_HALT)
//   - the halt opcode and a helper that recognises it
// -----------------------------------------------------------------------------
package pc_pkg;

    localparam logic [2:0] PC_SEQ  = 3'd0;
    localparam logic [2:0] PC_BR   = 3'd1;
    localparam logic [2:0] PC_REG  = 3'd2;
    localparam logic [2:0] PC_JMP  = 3'd3;
    localparam logic [2:0] PC_CALL = 3'd4;
    localparam logic [2:0] PC_RET  = 3'd5;

    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    function automatic logic is_halt_op(input logic [31:0] instr);
        return instr[31:26] == OP_HALT;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Bundles the control-unit side of the PC sequencer.
//   master : control unit (drives PCWre, PCSrc, Instruction, A_Data, Trap, Resume)
//   slave  : pc_sequencer  (drives PC, next, EPC, Halted, RasEmpty, RasFull,
//                           plus state/RasCount for observation)
// Handshake: there is no valid/ready pair. PCWre is a level "advance" enable
// sampled on every rising edge; the sequencer is always ready, so an edge with
// PCWre=1 in RUN consumes the current PCSrc/Instruction/A_Data. Trap and Resume
// are level-sampled on the same edges.
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    import pc_pkg::*;

    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic            PCWre;
    logic [2:0]      PCSrc;
    logic [31:0]     Instruction;
    logic [XLEN-1:0] A_Data;
    logic            Trap;
    logic            Resume;

    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] next;
    logic [XLEN-1:0] EPC;
    logic            Halted;
    logic            RasEmpty;
    logic            RasFull;
    state_e          state;
    logic [CW-1:0]   RasCount;

    modport master (
        output PCWre, PCSrc, Instruction, A_Data, Trap, Resume,
        input  PC, next, EPC, Halted, RasEmpty, RasFull, state, RasCount
    );

    modport slave (
        input  PCWre, PCSrc, Instruction, A_Data, Trap, Resume,
        output PC, next, EPC, Halted, RasEmpty, RasFull, state, RasCount
    );

endinterface

// File: rtl/pc_sequencer_ras.sv
// -----------------------------------------------------------------------------
// ret_addr_stack
// Circular return-address stack with a saturating occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the write pointer (overwrites the oldest
//                entry when full; count saturates at RAS_DEPTH)
//   pop        : drop the top entry (ignored when empty)
//   push_data  : address to push
//   top        : most recently pushed live entry
//   empty/full : count == 0 / count == RAS_DEPTH
//   count      : current occupancy
// -----------------------------------------------------------------------------
module ret_addr_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4,
    localparam int PW       = $clog2(RAS_DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full,
    output logic [CW-1:0]   count
);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q;     // next slot to write; top lives at ptr_q-1
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   top_idx;

    assign top_idx = ptr_q - PW'(1);
    assign top     = mem_q[top_idx];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(RAS_DEPTH));
    assign count   = cnt_q;

    // Entry contents need no reset; only pointer and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[ptr_q] <= push_data;
        end
    end

    // RAS_DEPTH is a power of two, so the pointer wraps naturally; a push
    // into a full stack lands on the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            ptr_q <= ptr_q + PW'(1);
            if (!full) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - PW'(1);
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer for the multi-cycle CPU: next-PC selection,
// RUN/HALT state machine with resume, trap redirect with EPC capture, and a
// return-address stack for call/return.
//   CLK : clock, all state changes on the rising edge
//   Rst : asynchronous active-low reset
//   bus : pc_sequencer_if.slave (control inputs, PC/next/EPC/status outputs)
// Parameters: XLEN (>= 32), RESET_VEC, TRAP_VEC, RAS_DEPTH (power of 2, >= 2)
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            Rst,
    pc_sequencer_if.slave   bus
);

    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    state_e          state_q;
    logic            halted_q;

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] jmp_tgt;
    logic [XLEN-1:0] reg_tgt;
    logic            halt_op;
    logic            advance;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;
    logic [CW-1:0]   ras_count;
    logic            unused_a_lsb;

    assign unused_a_lsb = ^bus.A_Data[1:0];

    assign pc_plus4 = pc_q + XLEN'(4);
    assign br_off   = {{(XLEN-18){bus.Instruction[15]}}, bus.Instruction[15:0], 2'b00};
    assign jmp_tgt  = {pc_q[XLEN-1:28], bus.Instruction[25:0], 2'b00};
    assign reg_tgt  = {bus.A_Data[XLEN-1:2], 2'b00};
    assign halt_op  = is_halt_op(bus.Instruction);

    // Next-PC candidate; all sums wrap modulo 2^XLEN.
    always_comb begin
        pc_d = pc_plus4;
        if (!Rst) begin
            pc_d = RESET_VEC;
        end else begin
            case (bus.PCSrc)
                PC_BR:            pc_d = pc_plus4 + br_off;
                PC_REG:           pc_d = reg_tgt;
                PC_JMP, PC_CALL:  pc_d = jmp_tgt;
                PC_RET:           pc_d = ras_empty ? reg_tgt : ras_top;
                default:          pc_d = pc_plus4;
            endcase
        end
    end

    // An advancing edge is the only one that moves PC to pc_d; Trap overrides
    // it, so a push/pop requested in a trap cycle never reaches the stack.
    assign advance  = (state_q == ST_RUN) && bus.PCWre && !halt_op && !bus.Trap;
    assign ras_push = advance && (bus.PCSrc == PC_CALL);
    assign ras_pop  = advance && (bus.PCSrc == PC_RET);

    ret_addr_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst_n     (Rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .count     (ras_count)
    );

    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            pc_q     <= RESET_VEC;
            epc_q    <= '0;
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else if (bus.Trap) begin
            epc_q    <= pc_q;
            pc_q     <= TRAP_VEC;
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.PCWre) begin
                        if (halt_op) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q <= pc_d;
                        end
                    end
                end
                ST_HALT: begin
                    if (bus.Resume) begin
                        pc_q     <= pc_plus4;
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC       = pc_q;
    assign bus.next     = pc_d;
    assign bus.EPC      = epc_q;
    assign bus.Halted   = halted_q;
    assign bus.RasEmpty = ras_empty;
    assign bus.RasFull  = ras_full;
    assign bus.state    = state_q;
    assign bus.RasCount = ras_count;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the multi-cycle CPU. It generalises the PC register with configurable address width and reset/trap vectors, and adds a return-address stack for call/return. It also has an explicit RUN/HALT state machine with resume and a trap redirect that saves the faulting PC. It sits between the control unit (PCWre, PCSrc, Trap, Resume) and the instruction memory address port.

## Interface
- XLEN, 32, address/data width; must be ≥ 32
- RESET_VEC, 0, PC value on reset
- TRAP_VEC, 32'h0000_0100, PC loaded on Trap
- RAS_DEPTH, 4, return-address stack entries; power of 2, ≥ 2

Ports:
- CLK  in  1  clock; all state changes on rising edge
- Rst  in  1  asynchronous reset, active-low
- PCWre  in  1  advance enable from control unit
- PCSrc  in  3  0 seq, 1 branch-rel, 2 reg-indirect, 3 jump-abs, 4 call, 5 return, 6–7 treated as 0
- Instruction  in  32  current instruction word
- A_Data  in  XLEN  register-file read port A
- Trap  in  1  exception request, level-sampled
- Resume  in  1  leave HALT
- PC  out  XLEN  current PC
- next  out  XLEN  combinational next-PC candidate
- EPC  out  XLEN  PC saved at last trap
- Halted  out  1  high in HALT state
- RasEmpty  out  1  stack count == 0
- RasFull  out  1  stack count == RAS_DEPTH

## Operation
- next selection:
  - Rst low: next = RESET_VEC.
  - PCSrc 0: PC+4.
  - PCSrc 1: PC+4+(sext(Instruction[15:0])<<2).
  - PCSrc 2: {A_Data[XLEN-1:2],2'b00}.
  - PCSrc 3/4: {PC[XLEN-1:28],Instruction[25:0],2'b00}.
  - PCSrc 5: RAS top if non-empty, else {A_Data[XLEN-1:2],2'b00}.
- Arithmetic: all sums are modulo 2^XLEN; wrap at the top of the address space is silent.
- States:
  - RUN: PC <= next when PCWre=1 and opcode Instruction[31:26] != 6'b111111.
  - RUN→HALT: opcode 6'b111111 with PCWre=1. PC is held.
  - HALT: PC held regardless of PCWre/PCSrc. The RAS is frozen.
  - HALT→RUN: Resume=1. PC <= PC+4 on that edge.
- Trap, highest priority, any state:
  - EPC <= PC; PC <= TRAP_VEC; state <= RUN.
  - The RAS is untouched, and any push/pop requested that cycle is suppressed.
- RAS push: PCSrc 4 with an advancing edge pushes PC+4.
  - When full, it overwrites the oldest entry (circular), and the count stays at RAS_DEPTH.
- RAS pop: PCSrc 5 with an advancing edge, non-empty: pop, count−1.
  - When empty, it falls back to A_Data and the count stays 0.
- Push and pop are mutually exclusive by encoding.
- Reset values: PC=RESET_VEC, EPC=0, Halted=0, state RUN, RAS count 0, RasEmpty=1, RasFull=0. RAS entry contents are don't-care.

## Timing
- Rst is asynchronous assert, with synchronous release expected from the reset synchroniser. Reset mid-operation clears the state immediately.
- PC, EPC, state and RAS update on the rising edge only. next, RasEmpty and RasFull are combinational from current state and inputs.
- Zero-cycle next latency; one-cycle PC latency from PCWre.
- Halted rises the edge after the halt opcode is accepted.
- Resume while in RUN is ignored.
- Trap and Resume in the same cycle: Trap wins.
- Trap and the halt opcode in the same cycle: Trap wins; no HALT entry.
- PCWre=0 in RUN: PC, state and RAS are held. Trap still acts.

## Structure
- Shared package pc_pkg holds:
  - PCSrc encodings (PC_SEQ, PC_BR, PC_REG, PC_JMP, PC_CALL, PC_RET).
  - State enum (ST_RUN, ST_HALT).
  - OP_HALT = 6'b111111.
- Sub-module ret_addr_stack (params XLEN, RAS_DEPTH).
  - Ports: push, pop, push_data, top, empty, full.
  - Implemented as a circular pointer plus saturating count.
- The sign extension is inline; no instance of the existing extender is needed.

## Test plan
- Reset: hold Rst=0 mid-run with PC=0x40 → PC=RESET_VEC (0) immediately, next=0. After release, PCWre pulses with PCSrc 0 → PC 4, 8, 12.
- Branch: PC=0x10, PCSrc=1, imm=16'hFFFC → next=0x04. With imm=0x0003 → next=0x20.
- Call/return: CALL at PC 0x100, then a nested CALL at 0x200, then RET, RET → PCs return to 0x204 then 0x104. RasEmpty=1 at the end.
- RAS overflow/underflow: RAS_DEPTH=4, 5 calls then 5 returns → the first 4 returns give the newest 4 addresses. The 5th return uses A_Data=0x3000 → PC=0x3000.
- Halt/resume: halt opcode at PC 0x50 with PCWre → Halted=1 and PC stays 0x50 across 10 PCWre pulses. Resume → PC=0x54, Halted=0.
- Trap priority: in HALT with PC 0x50, assert Trap and Resume together → PC=0x100, EPC=0x50, Halted=0, RAS count unchanged.
